// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares the single SRAM controller port between the instruction-fetch and
// data (load/store) requesters. One access is in flight at a time. Each access
// walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE: the winner is registered at the
// IDLE edge, a one-cycle read/write op is issued, the controller's two-cycle
// access is tracked, and the ack plus read data go back to the owner in RESP.
// When both sides request, data wins unless the fetch side has lost
// STARVE_LIMIT times in a row (STARVE_LIMIT = 0 gives pure data priority).

module sram_bus_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    // instruction fetch port (read only)
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_ack_o,
    output logic              inst_stall_o,

    // data load/store port
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_be_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ack_o,
    output logic              data_stall_o,

    // sram_controller side
    output logic              sram_read_op_o,
    output logic              sram_write_op_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic [3:0]        sram_mask_o,
    input  logic [DATA_W-1:0] sram_rdata_i,

    // status
    output logic              owner_o,
    output logic              busy_o
);

    // Counter wide enough to hold STARVE_LIMIT; never zero-width, even for 0.
    localparam int               CNT_W     = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
    localparam bit               STARVE_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q;        // 0 = inst, 1 = data
    logic                we_q;           // current access is a write
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          mask_q;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

    logic                any_req;
    logic                both_req;
    logic                force_inst;
    logic                grant_data;

    // Arbitration decision, only acted upon in IDLE.
    always_comb begin
        any_req    = inst_req_i | data_req_i;
        both_req   = inst_req_i & data_req_i;
        force_inst = STARVE_EN && (starve_cnt_q == LIMIT_C);
        grant_data = data_req_i & ~(inst_req_i & force_inst);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop
        // samples the pre-edge values, regardless of block ordering.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RESP always returns to IDLE so a requester still
    // holding req in its ack cycle is not resampled as a new access.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Access registers: capture the winner in IDLE, hold through RESP, clear
    // on the way back to IDLE so the controller bus idles at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= 4'b0000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_data;
                        if (grant_data) begin
                            we_q    <= data_we_i;
                            addr_q  <= data_addr_i;
                            wdata_q <= data_wdata_i;
                            mask_q  <= data_be_i;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= inst_addr_i;
                            wdata_q <= '0;
                            mask_q  <= 4'b1111;
                        end
                    end
                end
                ST_RESP: begin
                    // owner is kept: it reports the last access while idle
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    mask_q  <= 4'b0000;
                end
                default: ;
            endcase
        end
    end

    // Starvation counter next value: counts consecutive contested data wins.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE) begin
            if (!inst_req_i) begin
                starve_cnt_d = '0;
            end else if (both_req && grant_data) begin
                if (starve_cnt_q != LIMIT_C) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                // inst won, alone or by force
                starve_cnt_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Outputs decoded from state and the registered access.
    always_comb begin
        sram_read_op_o  = 1'b0;
        sram_write_op_o = 1'b0;
        inst_ack_o      = 1'b0;
        data_ack_o      = 1'b0;
        inst_rdata_o    = '0;
        data_rdata_o    = '0;

        if (state_q == ST_ISSUE) begin
            sram_read_op_o  = ~owner_q | ~we_q;
            sram_write_op_o = owner_q & we_q;
        end

        if (state_q == ST_RESP) begin
            if (owner_q) begin
                data_ack_o = 1'b1;
                if (!we_q) begin
                    data_rdata_o = sram_rdata_i;
                end
            end else begin
                inst_ack_o   = 1'b1;
                inst_rdata_o = sram_rdata_i;
            end
        end

        inst_stall_o = inst_req_i & ~inst_ack_o;
        data_stall_o = data_req_i & ~data_ack_o;
        sram_addr_o  = addr_q;
        sram_wdata_o = wdata_q;
        sram_mask_o  = mask_q;
        owner_o      = owner_q;
        busy_o       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter (default parameters).
// Inputs change 2 time units after each rising edge; outputs are sampled one
// unit later, well away from the next edge. "Cycle n" is the interval after
// rising edge n, counted from the edge that starts each scenario.

module tb_sram_bus_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ack;
    logic              inst_stall;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_be;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ack;
    logic              data_stall;
    logic              sram_read_op;
    logic              sram_write_op;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [3:0]        sram_mask;
    logic [DATA_W-1:0] sram_rdata;
    logic              owner;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_i      (inst_req),
        .inst_addr_i     (inst_addr),
        .inst_rdata_o    (inst_rdata),
        .inst_ack_o      (inst_ack),
        .inst_stall_o    (inst_stall),
        .data_req_i      (data_req),
        .data_we_i       (data_we),
        .data_addr_i     (data_addr),
        .data_wdata_i    (data_wdata),
        .data_be_i       (data_be),
        .data_rdata_o    (data_rdata),
        .data_ack_o      (data_ack),
        .data_stall_o    (data_stall),
        .sram_read_op_o  (sram_read_op),
        .sram_write_op_o (sram_write_op),
        .sram_addr_o     (sram_addr),
        .sram_wdata_o    (sram_wdata),
        .sram_mask_o     (sram_mask),
        .sram_rdata_i    (sram_rdata),
        .owner_o         (owner),
        .busy_o          (busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        data_be    = 4'b0000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_op"}, sram_read_op, 0);
        check({tag, "_wr_op"}, sram_write_op, 0);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_wdata"}, sram_wdata, 0);
        check({tag, "_mask"}, sram_mask, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_iack"}, inst_ack, 0);
        check({tag, "_dack"}, data_ack, 0);
        check({tag, "_irdata"}, inst_rdata, 0);
        check({tag, "_drdata"}, data_rdata, 0);
    endtask

    // Both requesters busy: fetch held until its ack, data re-requesting
    // continuously until one data ack after the fetch ack.
    task automatic run_starve(output int d_before, output int d_after, output int n_inst);
        bit drop_inst = 0;
        bit drop_data = 0;
        bit done      = 0;
        d_before = 0;
        d_after  = 0;
        n_inst   = 0;
        inst_req  = 1'b1;
        inst_addr = 22'h00400;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 22'h00300;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) next_cycle();
            if (drop_inst) inst_req = 1'b0;
            if (drop_data) data_req = 1'b0;
            settle();
            check("starve_op_excl", sram_read_op & sram_write_op, 0);
            check("starve_ack_excl", inst_ack & data_ack, 0);
            if (data_ack) begin
                if (n_inst == 0) d_before++;
                else begin
                    d_after++;
                    drop_data = 1;
                end
            end
            if (inst_ack) begin
                n_inst++;
                drop_inst = 1;
            end
            if (!data_req && !inst_req && !busy) begin
                done = 1;
                break;
            end
        end
        check("starve_done", done, 1);
    endtask

    initial begin
        int d_before, d_after, n_inst;
        int ack_cyc [3];
        logic [ADDR_W-1:0] op_addr [3];
        int n_ack, n_op;
        bit bump, finished;

        idle_inputs();
        sram_rdata = '0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
        check_all_zero("reset");
        check("reset_istall", inst_stall, 0);
        check("reset_dstall", data_stall, 0);

        // 1: single fetch
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 22'h00100;
        sram_rdata = 32'hDEADBEEF;
        settle();
        check("t1_c0_stall", inst_stall, 1);
        check("t1_c0_rdop", sram_read_op, 0);
        check("t1_c0_busy", busy, 0);
        next_cycle(); settle();
        check("t1_c1_rdop", sram_read_op, 1);
        check("t1_c1_wrop", sram_write_op, 0);
        check("t1_c1_addr", sram_addr, 22'h00100);
        check("t1_c1_mask", sram_mask, 4'b1111);
        check("t1_c1_owner", owner, 0);
        check("t1_c1_stall", inst_stall, 1);
        next_cycle(); settle();
        check("t1_c2_rdop", sram_read_op, 0);
        check("t1_c2_ack", inst_ack, 0);
        check("t1_c2_rdata", inst_rdata, 0);
        check("t1_c2_stall", inst_stall, 1);
        check("t1_c2_addr", sram_addr, 22'h00100);
        next_cycle(); settle();
        check("t1_c3_ack", inst_ack, 1);
        check("t1_c3_rdata", inst_rdata, 32'hDEADBEEF);
        check("t1_c3_stall", inst_stall, 0);
        check("t1_c3_dack", data_ack, 0);
        next_cycle();
        inst_req = 1'b0;
        settle();
        check("t1_c4_busy", busy, 0);
        check("t1_c4_addr", sram_addr, 0);
        check("t1_c4_ack", inst_ack, 0);

        // 2: data write
        next_cycle();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 22'h00204;
        data_wdata = 32'h12345678;
        data_be    = 4'b0011;
        sram_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            settle();
            check("t2_rdop_never", sram_read_op, 0);
            check("t2_wrop", sram_write_op, (c == 1));
            check("t2_dack", data_ack, (c == 3));
            check("t2_drdata", data_rdata, 0);
            if (c == 1) begin
                check("t2_addr", sram_addr, 22'h00204);
                check("t2_wdata", sram_wdata, 32'h12345678);
                check("t2_mask", sram_mask, 4'b0011);
                check("t2_owner", owner, 1);
            end
        end
        next_cycle();
        data_req = 1'b0;
        data_we  = 1'b0;
        settle();
        check("t2_c4_busy", busy, 0);
        check("t2_c4_owner", owner, 1);

        // 3: simultaneous requests, data served first
        next_cycle();
        inst_req   = 1'b1;
        inst_addr  = 22'h00100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 22'h00200;
        sram_rdata = 32'h0BADF00D;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) data_req = 1'b0;
            settle();
            check("t3_rdop", sram_read_op, (c == 1 || c == 5));
            check("t3_wrop", sram_write_op, 0);
            check("t3_dack", data_ack, (c == 3));
            check("t3_iack", inst_ack, (c == 7));
            if (c == 1) begin
                check("t3_c1_owner", owner, 1);
                check("t3_c1_addr", sram_addr, 22'h00200);
            end
            if (c == 3) check("t3_c3_drdata", data_rdata, 32'h0BADF00D);
            if (c == 5) begin
                check("t3_c5_owner", owner, 0);
                check("t3_c5_addr", sram_addr, 22'h00100);
            end
            if (c == 7) check("t3_c7_irdata", inst_rdata, 32'h0BADF00D);
        end
        next_cycle();
        inst_req = 1'b0;
        settle();
        check("t3_end_busy", busy, 0);

        // 4: starvation limit, run twice to show the counter restarts from 0
        for (int r = 0; r < 2; r++) begin
            next_cycle();
            run_starve(d_before, d_after, n_inst);
            check("t4_data_before_inst", d_before, 4);
            check("t4_inst_acks", n_inst, 1);
            check("t4_data_after_inst", d_after, 1);
        end

        // 5: reset during WAIT of a data read
        next_cycle();
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 22'h00500;
        sram_rdata = 32'h55AA55AA;
        next_cycle(); settle();
        check("t5_c1_rdop", sram_read_op, 1);
        check("t5_c1_owner", owner, 1);
        next_cycle();
        rst      = 1'b1;
        data_req = 1'b0;
        settle();
        check("t5_c2_busy", busy, 1);
        next_cycle();
        rst = 1'b0;
        settle();
        check_all_zero("t5_post_rst");
        for (int c = 0; c < 3; c++) begin
            next_cycle(); settle();
            check("t5_no_dack", data_ack, 0);
            check("t5_idle", busy, 0);
        end
        next_cycle();
        inst_req  = 1'b1;
        inst_addr = 22'h00600;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            settle();
            check("t5_new_rdop", sram_read_op, (c == 1));
            check("t5_new_iack", inst_ack, (c == 3));
        end
        next_cycle();
        inst_req = 1'b0;

        // 6: back-to-back fetches, re-requested the cycle after each ack
        next_cycle();
        inst_req  = 1'b1;
        inst_addr = 22'h00000;
        n_ack = 0;
        n_op  = 0;
        bump  = 0;
        finished = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) next_cycle();
            if (bump) begin
                inst_addr = inst_addr + 22'd4;
                bump = 0;
            end
            if (n_ack == 3) inst_req = 1'b0;
            settle();
            if (sram_read_op && n_op < 3) begin
                op_addr[n_op] = sram_addr;
                n_op++;
            end
            if (inst_ack && n_ack < 3) begin
                ack_cyc[n_ack] = c;
                n_ack++;
                bump = 1;
            end
            if (n_ack == 3 && !inst_req) begin
                finished = 1;
                break;
            end
        end
        check("t6_done", finished, 1);
        check("t6_n_ack", n_ack, 3);
        check("t6_n_op", n_op, 3);
        if (n_ack == 3 && n_op == 3) begin
            check("t6_first_ack", ack_cyc[0], 3);
            check("t6_gap1", ack_cyc[1] - ack_cyc[0], 4);
            check("t6_gap2", ack_cyc[2] - ack_cyc[1], 4);
            check("t6_addr0", op_addr[0], 22'h00000);
            check("t6_addr1", op_addr[1], 22'h00004);
            check("t6_addr2", op_addr[2], 22'h00008);
        end
        settle();
        check("t6_end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the DUT stalls a scenario loop indefinitely.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
